// File: rtl/rf_bank_read_arbiter.sv
// Register-file bank front end: 4 banks x 8 entries, per-bank request FIFOs, one response per bank.
// Define RF_WB_FORWARD_EN to let writebacks proceed alongside reads with write-to-read forwarding.
module rf_bank_read_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 3,
   parameter int unsigned QDEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rq0_vld,
   input  logic [4:0]          rq0_reg_id,
   input  logic [TAG_W-1:0]    rq0_tag,
   input  logic                rq1_vld,
   input  logic [4:0]          rq1_reg_id,
   input  logic [TAG_W-1:0]    rq1_tag,
   output logic                req_rdy,
   input  logic                wb_en,
   input  logic [4:0]          wb_reg_id,
   input  logic [DATA_W-1:0]   wb_data,
   output logic [4*DATA_W-1:0] bk_data,
   output logic [3:0]          bk_vld,
   output logic [4*TAG_W-1:0]  bk_tag,
   output logic [3:0]          bk_bz
);

   localparam int unsigned NB = 4;
   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = 3 + TAG_W;

   logic [DATA_W-1:0] rf_q   [NB][8];
   logic [EW-1:0]     fifo_q [NB][QDEPTH];
   logic [PW-1:0]     rptr_q [NB];
   logic [PW-1:0]     wptr_q [NB];
   logic [CW-1:0]     cnt_q  [NB];
   logic [DATA_W-1:0] data_q [NB];
   logic [TAG_W-1:0]  tag_q  [NB];
   logic [NB-1:0]     vld_q, bz_q;

   logic [NB-1:0]     push0, push1, wr_hit, pop, stall;
   logic [EW-1:0]     head    [NB];
   logic [DATA_W-1:0] rd_data [NB];
   logic              rdy;

   // Two slots must be free in every bank, since both requests may target the same one.
   always_comb begin
      rdy = 1'b1;
      for (int i = 0; i < NB; i++) begin
         if (cnt_q[i] > CW'(QDEPTH - 2)) rdy = 1'b0;
      end
   end

   assign req_rdy = rdy;

   for (genvar g = 0; g < NB; g++) begin : g_bank
      assign push0[g]  = rq0_vld && rdy && (rq0_reg_id[4:3] == 2'(g));
      assign push1[g]  = rq1_vld && rdy && (rq1_reg_id[4:3] == 2'(g));
      assign wr_hit[g] = wb_en && (wb_reg_id[4:3] == 2'(g));
      assign head[g]   = fifo_q[g][rptr_q[g]];
`ifdef RF_WB_FORWARD_EN
      assign stall[g]   = 1'b0;
      assign rd_data[g] = (wr_hit[g] && (head[g][EW-1 -: 3] == wb_reg_id[2:0])) ?
                          wb_data : rf_q[g][head[g][EW-1 -: 3]];
`else
      assign stall[g]   = wr_hit[g];
      assign rd_data[g] = rf_q[g][head[g][EW-1 -: 3]];
`endif
      assign pop[g] = !stall[g] && (cnt_q[g] != '0);

      assign bk_data[g*DATA_W +: DATA_W] = data_q[g];
      assign bk_tag[g*TAG_W +: TAG_W]    = tag_q[g];
   end

   assign bk_vld = vld_q;
   assign bk_bz  = bz_q;

   // rq0 lands ahead of rq1 when both hit the same bank.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (push0[i]) fifo_q[i][wptr_q[i]] <= {rq0_reg_id[2:0], rq0_tag};
         if (push1[i]) fifo_q[i][wptr_q[i] + PW'(push0[i])] <= {rq1_reg_id[2:0], rq1_tag};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NB; i++) begin
            for (int e = 0; e < 8; e++) rf_q[i][e] <= '0;
            rptr_q[i] <= '0;
            wptr_q[i] <= '0;
            cnt_q[i]  <= '0;
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         vld_q <= '0;
         bz_q  <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            wptr_q[i] <= wptr_q[i] + PW'(push0[i]) + PW'(push1[i]);
            if (pop[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
            cnt_q[i] <= cnt_q[i] + CW'(push0[i]) + CW'(push1[i]) - CW'(pop[i]);
            bz_q[i]  <= stall[i];
            vld_q[i] <= pop[i];
            if (pop[i]) begin
               data_q[i] <= rd_data[i];
               tag_q[i]  <= head[i][TAG_W-1:0];
            end
         end
         if (wb_en) rf_q[wb_reg_id[4:3]][wb_reg_id[2:0]] <= wb_data;
      end
   end

endmodule

// File: tb/tb_rf_bank_read_arbiter.sv
// Directed bench for rf_bank_read_arbiter; expected values are hand-computed per scenario.
module tb_rf_bank_read_arbiter;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              rq0_vld, rq1_vld, wb_en;
   logic [4:0]        rq0_reg_id, rq1_reg_id, wb_reg_id;
   logic [TAG_W-1:0]  rq0_tag, rq1_tag;
   logic [DATA_W-1:0] wb_data;
   logic              req_rdy;
   logic [4*DATA_W-1:0] bk_data;
   logic [3:0]        bk_vld, bk_bz;
   logic [4*TAG_W-1:0] bk_tag;

   int errors = 0;
   int checks = 0;

   rf_bank_read_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .QDEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rq0_vld    (rq0_vld),
      .rq0_reg_id (rq0_reg_id),
      .rq0_tag    (rq0_tag),
      .rq1_vld    (rq1_vld),
      .rq1_reg_id (rq1_reg_id),
      .rq1_tag    (rq1_tag),
      .req_rdy    (req_rdy),
      .wb_en      (wb_en),
      .wb_reg_id  (wb_reg_id),
      .wb_data    (wb_data),
      .bk_data    (bk_data),
      .bk_vld     (bk_vld),
      .bk_tag     (bk_tag),
      .bk_bz      (bk_bz)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] dat(input int b);
      return bk_data[b*DATA_W +: DATA_W];
   endfunction

   function automatic logic [TAG_W-1:0] tg(input int b);
      return bk_tag[b*TAG_W +: TAG_W];
   endfunction

   task automatic idle_inputs();
      rq0_vld = 0; rq1_vld = 0; wb_en = 0;
      rq0_reg_id = '0; rq1_reg_id = '0; wb_reg_id = '0;
      rq0_tag = '0; rq1_tag = '0; wb_data = '0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vld", bk_vld, 4'h0);
      check("rst_bz", bk_bz, 4'h0);
      check("rst_data", bk_data, '0);
      check("rst_tag", bk_tag, '0);
      check("rst_rdy", req_rdy, 1'b1);
      rst = 1'b0;
      step();

      // 1: preload reg 9, then single read with one-edge latency
      wb_en = 1; wb_reg_id = 5'd9; wb_data = 32'hDEADBEEF;
      step();
`ifdef RF_WB_FORWARD_EN
      check("t1_wb_bz", bk_bz, 4'b0000);
`else
      check("t1_wb_bz", bk_bz, 4'b0010);
`endif
      wb_en = 0;
      rq0_vld = 1; rq0_reg_id = 5'd9; rq0_tag = 3'd3;
      step();
      rq0_vld = 0;
      check("t1_vld_n", bk_vld, 4'b0000);
      step();
      check("t1_vld_n1", bk_vld, 4'b0010);
      check("t1_data", dat(1), 32'hDEADBEEF);
      check("t1_tag", tg(1), 3'd3);
      step();
      check("t1_vld_after", bk_vld, 4'b0000);
      check("t1_hold", dat(1), 32'hDEADBEEF);

      // 2: same-bank pair, rq0 first
      rq0_vld = 1; rq0_reg_id = 5'd2; rq0_tag = 3'd0;
      rq1_vld = 1; rq1_reg_id = 5'd5; rq1_tag = 3'd1;
      step();
      rq0_vld = 0; rq1_vld = 0;
      step();
      check("t2_vld_a", bk_vld, 4'b0001);
      check("t2_tag_a", tg(0), 3'd0);
      step();
      check("t2_vld_b", bk_vld, 4'b0001);
      check("t2_tag_b", tg(0), 3'd1);
      step();
      check("t2_vld_end", bk_vld, 4'b0000);

      // 3: writeback collides with a queued read on bank 2
      rq0_vld = 1; rq0_reg_id = 5'd16; rq0_tag = 3'd2;
      step();
      rq0_vld = 0;
      wb_en = 1; wb_reg_id = 5'd20; wb_data = 32'h55;
      step();
      wb_en = 0;
`ifdef RF_WB_FORWARD_EN
      check("t3_bz", bk_bz, 4'b0000);
      check("t3_vld", bk_vld, 4'b0100);
      check("t3_tag", tg(2), 3'd2);
      step();
      check("t3_vld_end", bk_vld, 4'b0000);
`else
      check("t3_bz", bk_bz, 4'b0100);
      check("t3_vld", bk_vld, 4'b0000);
      step();
      check("t3_bz_clr", bk_bz, 4'b0000);
      check("t3_vld_late", bk_vld, 4'b0100);
      check("t3_tag", tg(2), 3'd2);
      check("t3_data", dat(2), 32'h0);
`endif
      rq0_vld = 1; rq0_reg_id = 5'd20; rq0_tag = 3'd5;
      step();
      rq0_vld = 0;
      step();
      check("t3_raw_vld", bk_vld, 4'b0100);
      check("t3_raw_data", dat(2), 32'h55);
      step();

`ifndef RF_WB_FORWARD_EN
      // 4: backpressure on bank 3 under continuous writeback
      wb_en = 1; wb_reg_id = 5'd24; wb_data = 32'h11;
      rq0_vld = 1; rq0_reg_id = 5'd25; rq0_tag = 3'd4;
      rq1_vld = 1; rq1_reg_id = 5'd26; rq1_tag = 3'd5;
      check("t4_rdy0", req_rdy, 1'b1);
      step();
      rq1_vld = 0;
      rq0_reg_id = 5'd27; rq0_tag = 3'd6;
      check("t4_rdy2", req_rdy, 1'b1);
      step();
      rq0_reg_id = 5'd28; rq0_tag = 3'd7;
      check("t4_rdy3", req_rdy, 1'b0);
      step();
      check("t4_stall_bz", bk_bz, 4'b1000);
      check("t4_stall_vld", bk_vld, 4'b0000);
      check("t4_stall_rdy", req_rdy, 1'b0);
      step();
      wb_en = 0;
      step();
      check("t4_r0_vld", bk_vld, 4'b1000);
      check("t4_r0_tag", tg(3), 3'd4);
      check("t4_rdy_back", req_rdy, 1'b1);
      step();
      rq0_vld = 0;
      check("t4_r1_tag", tg(3), 3'd5);
      step();
      check("t4_r2_tag", tg(3), 3'd6);
      step();
      check("t4_r3_vld", bk_vld, 4'b1000);
      check("t4_r3_tag", tg(3), 3'd7);
      check("t4_r3_data", dat(3), 32'h0);
      step();
      check("t4_drained", bk_vld, 4'b0000);
      check("t4_bz_clr", bk_bz, 4'b0000);
`endif

`ifdef RF_WB_FORWARD_EN
      // 5: writeback forwarded into the read dequeued at the same edge
      rq0_vld = 1; rq0_reg_id = 5'd7; rq0_tag = 3'd1;
      step();
      rq0_vld = 0;
      wb_en = 1; wb_reg_id = 5'd7; wb_data = 32'h1234;
      step();
      wb_en = 0;
      check("t5_vld", bk_vld, 4'b0001);
      check("t5_fwd", dat(0), 32'h1234);
      step();
`endif

      // 6: async reset with two reads queued in bank 1
      rq0_vld = 1; rq0_reg_id = 5'd10; rq0_tag = 3'd1;
      rq1_vld = 1; rq1_reg_id = 5'd11; rq1_tag = 3'd2;
      step();
      rq0_vld = 0; rq1_vld = 0;
      check("t6_pre_rst_vld", bk_vld, 4'b0000);
      #1 rst = 1'b1;
      #1;
      check("t6_rst_vld", bk_vld, 4'b0000);
      check("t6_rst_rdy", req_rdy, 1'b1);
      step();
      rst = 1'b0;
      step();
      check("t6_no_stale0", bk_vld, 4'b0000);
      step();
      check("t6_no_stale1", bk_vld, 4'b0000);
      rq0_vld = 1; rq0_reg_id = 5'd9; rq0_tag = 3'd6;
      rq1_vld = 1; rq1_reg_id = 5'd20; rq1_tag = 3'd7;
      step();
      rq0_vld = 0; rq1_vld = 0;
      step();
      check("t6_rd_vld", bk_vld, 4'b0110);
      check("t6_rd9", dat(1), 32'h0);
      check("t6_tag9", tg(1), 3'd6);
      check("t6_rd20", dat(2), 32'h0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
